// File: rtl/pattern_gen_pkg.sv
// Shared types for the multi-channel pattern generator: pattern modes, line FSM states
// and a helper for the full-scale pixel level.
package pattern_gen_pkg;

    typedef enum logic [2:0] {
        M_OFF   = 3'd0,
        M_COUNT = 3'd1,
        M_CONST = 3'd2,
        M_CHK_W = 3'd3,
        M_CHK_B = 3'd4,
        M_RAMP  = 3'd5,
        M_BARS  = 3'd6,
        M_RSVD  = 3'd7
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_ACTIVE = 3'd2
    } state_e;

    function automatic logic [63:0] pix_max(input int dw);
        return (64'd1 << dw) - 64'd1;
    endfunction

endpackage

// File: rtl/pattern_gen_mc_if.sv
// Sync/config inputs and pixel outputs of the pattern generator, bundled as one bus.
// The timing source is the master; the generator is the slave.
interface pattern_gen_mc_if #(
    parameter int DW = 12,
    parameter int CH = 3,
    parameter int YW = 12
);
    logic             f_sync;
    logic             sync;
    logic [2:0]       mode;
    logic [DW-1:0]    const_val;
    logic [3:0]       dx;
    logic [3:0]       dy;
    logic [2:0]       cell_log2;
    logic [CH*DW-1:0] pix;
    logic             pix_valid;
    logic [YW-1:0]    line_cnt;
    logic [2:0]       state;

    modport master (
        output f_sync, sync, mode, const_val, dx, dy, cell_log2,
        input  pix, pix_valid, line_cnt, state
    );

    modport slave (
        input  f_sync, sync, mode, const_val, dx, dy, cell_log2,
        output pix, pix_valid, line_cnt, state
    );
endinterface

// File: rtl/pg_line_timer.sv
// Line/frame timing: FSM, x/y counters, colour-bar counter, incremental ramp
// accumulators and the configuration shadows latched at frame start.
module pg_line_timer
    import pattern_gen_pkg::*;
#(
    parameter int DW       = 12,
    parameter int LINE_LEN = 1350,
    parameter int YW       = 12,
    parameter int XW       = $clog2(LINE_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sync,
    input  logic          f_sync,
    input  logic [2:0]    mode,
    input  logic [DW-1:0] const_val,
    input  logic [3:0]    dx,
    input  logic [3:0]    dy,
    input  logic [2:0]    cell_log2,
    output state_e        state,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [2:0]    bar,
    output logic [DW-1:0] ramp,
    output mode_e         mode_s,
    output logic [DW-1:0] const_s,
    output logic [2:0]    cell_s
);
    localparam int BAR_W = LINE_LEN / 8;
    localparam int BW    = $clog2(BAR_W);

    state_e        state_nx;
    logic          line_start;
    logic          frame_start;
    logic [3:0]    dx_s;
    logic [3:0]    dy_s;
    logic [DW-1:0] row;
    logic [BW-1:0] bar_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // NOTE: every output of a combinational block gets a default first, so no path
    // through the case leaves a signal unassigned and a latch is never inferred.
    always_comb begin
        state_nx    = state;
        line_start  = 1'b0;
        frame_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (sync && f_sync) begin
                    line_start  = 1'b1;
                    frame_start = 1'b1;
                    state_nx    = S_ACTIVE;
                end
            end
            S_WAIT: begin
                if (sync) begin
                    line_start  = 1'b1;
                    frame_start = f_sync;
                    state_nx    = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (sync) begin
                    line_start  = 1'b1;
                    frame_start = f_sync;
                end else if (x == XW'(LINE_LEN - 1)) begin
                    state_nx = S_WAIT;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x       <= '0;
            y       <= '0;
            bar     <= '0;
            bar_pos <= '0;
            row     <= '0;
            ramp    <= '0;
            mode_s  <= M_OFF;
            const_s <= '0;
            cell_s  <= '0;
            dx_s    <= '0;
            dy_s    <= '0;
        end else if (line_start) begin
            x       <= '0;
            bar     <= '0;
            bar_pos <= '0;
            if (frame_start) begin
                y       <= '0;
                row     <= '0;
                ramp    <= '0;
                mode_s  <= mode_e'(mode);
                const_s <= const_val;
                cell_s  <= cell_log2;
                dx_s    <= dx;
                dy_s    <= dy;
            end else begin
                y    <= y + 1'b1;
                row  <= row + DW'(dy_s);
                ramp <= row + DW'(dy_s);
            end
        end else if (state == S_ACTIVE) begin
            if (x != XW'(LINE_LEN - 1)) x <= x + 1'b1;
            ramp <= ramp + DW'(dx_s);
            // Bar index advances every BAR_W pixels and sticks at the last bar.
            if (bar_pos == BW'(BAR_W - 1)) begin
                bar_pos <= '0;
                if (bar != 3'd7) bar <= bar + 1'b1;
            end else begin
                bar_pos <= bar_pos + 1'b1;
            end
        end
    end
endmodule

// File: rtl/pattern_gen_mc.sv
// Multi-channel test pattern generator: evaluates the pixel function on the line
// timer's (x, y) and registers pixel, valid and line index together.
module pattern_gen_mc
    import pattern_gen_pkg::*;
#(
    parameter int DW       = 12,
    parameter int CH       = 3,
    parameter int LINE_LEN = 1350,
    parameter int YW       = 12
) (
    input logic              clk,
    input logic              rst_n,
    pattern_gen_mc_if.slave  bus
);
    localparam int            XW  = $clog2(LINE_LEN);
    localparam logic [DW-1:0] MAX = DW'(pix_max(DW));

    state_e           state;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [2:0]       bar;
    logic [DW-1:0]    ramp;
    mode_e            mode_s;
    logic [DW-1:0]    const_s;
    logic [2:0]       cell_s;
    logic [DW-1:0]    level;
    logic [XW-1:0]    xs;
    logic [YW-1:0]    ys;
    logic [CH*DW-1:0] pix_nx;

    pg_line_timer #(.DW(DW), .LINE_LEN(LINE_LEN), .YW(YW), .XW(XW)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync      (bus.sync),
        .f_sync    (bus.f_sync),
        .mode      (bus.mode),
        .const_val (bus.const_val),
        .dx        (bus.dx),
        .dy        (bus.dy),
        .cell_log2 (bus.cell_log2),
        .state     (state),
        .x         (x),
        .y         (y),
        .bar       (bar),
        .ramp      (ramp),
        .mode_s    (mode_s),
        .const_s   (const_s),
        .cell_s    (cell_s)
    );

    always_comb begin
        level  = '0;
        xs     = x >> cell_s;
        ys     = y >> cell_s;
        case (mode_s)
            M_COUNT: level = DW'(x);
            M_CONST: level = const_s;
            M_CHK_W: level = (xs[0] ^ ys[0]) ? '0 : MAX;
            M_CHK_B: level = (xs[0] ^ ys[0]) ? MAX : '0;
            M_RAMP:  level = ramp;
            default: level = '0;
        endcase
        pix_nx = {CH{level}};
        // Colour bars: channel k follows bit (k mod 3) of the bar index.
        if (mode_s == M_BARS) begin
            for (int k = 0; k < CH; k++) pix_nx[k*DW +: DW] = bar[k % 3] ? MAX : '0;
        end
        if (state != S_ACTIVE) pix_nx = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pix       <= '0;
            bus.pix_valid <= 1'b0;
            bus.line_cnt  <= '0;
        end else begin
            bus.pix       <= pix_nx;
            bus.pix_valid <= (state == S_ACTIVE);
            bus.line_cnt  <= y;
        end
    end

    assign bus.state = state;
endmodule

// File: tb/tb_pattern_gen_mc.sv
// Randomised self-checking bench for pattern_gen_mc against an arithmetic pixel model.
module tb_pattern_gen_mc;
    localparam int DW    = 12;
    localparam int CH    = 3;
    localparam int LL    = 1350;
    localparam int YW    = 12;
    localparam int BAR_W = LL / 8;
    localparam int MAXV  = (1 << DW) - 1;

    typedef logic [YW+CH*DW:0] obs_t;   // {valid, line_cnt, pix}

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #8 clk = ~clk;

    pattern_gen_mc_if #(.DW(DW), .CH(CH), .YW(YW)) bus ();

    pattern_gen_mc #(.DW(DW), .CH(CH), .LINE_LEN(LL), .YW(YW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Values currently driven on the config inputs, and the copy latched at frame start.
    int d_mode, d_cv, d_dx, d_dy, d_c;
    int m_mode, m_cv, m_dx, m_dy, m_c;

    obs_t cap[$];

    function automatic logic [CH*DW-1:0] model_pix(input int x, input int y);
        int lvl;
        int bar;
        logic [CH*DW-1:0] p;
        lvl = 0;
        case (m_mode)
            1: lvl = x % (1 << DW);
            2: lvl = m_cv;
            3: lvl = (((x >> m_c) ^ (y >> m_c)) & 1) != 0 ? 0 : MAXV;
            4: lvl = (((x >> m_c) ^ (y >> m_c)) & 1) != 0 ? MAXV : 0;
            5: lvl = (x * m_dx + y * m_dy) % (1 << DW);
            default: lvl = 0;
        endcase
        for (int k = 0; k < CH; k++) p[k*DW +: DW] = DW'(lvl);
        if (m_mode == 6) begin
            bar = x / BAR_W;
            if (bar > 7) bar = 7;
            for (int k = 0; k < CH; k++) p[k*DW +: DW] = ((bar >> (k % 3)) & 1) != 0 ? DW'(MAXV) : '0;
        end
        return p;
    endfunction

    function automatic obs_t model_obs(input int x, input int y);
        return {1'b1, YW'(y % (1 << YW)), model_pix(x, y)};
    endfunction

    task automatic set_cfg(input int mode, input int cv, input int dx, input int dy, input int c);
        d_mode = mode; d_cv = cv; d_dx = dx; d_dy = dy; d_c = c;
        bus.mode      = 3'(mode);
        bus.const_val = DW'(cv);
        bus.dx        = 4'(dx);
        bus.dy        = 4'(dy);
        bus.cell_log2 = 3'(c);
    endtask

    // Drive one sync pulse (with f_sync when fs) for one sampling edge; returns on the
    // falling edge after that edge.
    task automatic pulse(input bit fs);
        bus.sync   = 1'b1;
        bus.f_sync = fs;
        if (fs) begin
            m_mode = d_mode; m_cv = d_cv; m_dx = d_dx; m_dy = d_dy; m_c = d_c;
        end
        @(negedge clk);
        bus.sync   = 1'b0;
        bus.f_sync = 1'b0;
    endtask

    task automatic capture(input int n);
        cap.delete();
        repeat (n) begin
            @(negedge clk);
            cap.push_back({bus.pix_valid, bus.line_cnt, bus.pix});
        end
    endtask

    task automatic test_reset();
        obs_t z;
        z = '0;
        set_cfg(0, 0, 0, 0, 0);
        bus.sync = 1'b0; bus.f_sync = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus.pix_valid, bus.line_cnt, bus.pix, bus.state} !== {z, 3'd0})
            $display("FAIL reset_init: got valid=%0b line=%0d pix=%h state=%0d, expected all 0",
                     bus.pix_valid, bus.line_cnt, bus.pix, bus.state);
        else n_pass++;
        rst_n = 1'b1;
        set_cfg(1, 0, 0, 0, 0);
        pulse(0);                      // sync without f_sync in IDLE is ignored
        capture(4);
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (cap[i] !== z || bus.state !== 3'd0)
                $display("FAIL idle_sync_ignored i=%0d: got %h state=%0d, expected 0 state=0", i, cap[i], bus.state);
            else n_pass++;
        end
        pulse(1);
        capture(100);
        n_total++;
        if (cap[99] !== model_obs(99, 0))
            $display("FAIL reset_pre_line: got %h, expected %h", cap[99], model_obs(99, 0));
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.pix_valid, bus.line_cnt, bus.pix, bus.state} !== {z, 3'd0})
            $display("FAIL reset_mid_line: got valid=%0b line=%0d pix=%h state=%0d, expected all 0",
                     bus.pix_valid, bus.line_cnt, bus.pix, bus.state);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        capture(5);
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (cap[i] !== z || bus.state !== 3'd0)
                $display("FAIL reset_no_partial i=%0d: got %h state=%0d, expected 0 state=0", i, cap[i], bus.state);
            else n_pass++;
        end
    endtask

    task automatic test_count();
        set_cfg(1, 0, 0, 0, 0);
        pulse(1);
        capture(LL);
        for (int i = 0; i < LL; i++) begin
            n_total++;
            if (cap[i] !== model_obs(i, 0))
                $display("FAIL count_line0 x=%0d: got %h, expected %h", i, cap[i], model_obs(i, 0));
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if ({bus.pix_valid, bus.pix, bus.state} !== {1'b0, {(CH*DW){1'b0}}, 3'd1})
            $display("FAIL count_end: got valid=%0b pix=%h state=%0d, expected valid=0 pix=0 state=1",
                     bus.pix_valid, bus.pix, bus.state);
        else n_pass++;
        bus.f_sync = 1'b1;            // f_sync alone is ignored
        @(negedge clk);
        bus.f_sync = 1'b0;
        capture(3);
        n_total++;
        if (cap[2] !== '0 || bus.state !== 3'd1)
            $display("FAIL fsync_alone: got %h state=%0d, expected 0 state=1", cap[2], bus.state);
        else n_pass++;
        pulse(0);
        capture(LL);
        for (int i = 0; i < LL; i++) begin
            n_total++;
            if (cap[i] !== model_obs(i, 1))
                $display("FAIL count_line1 x=%0d: got %h, expected %h", i, cap[i], model_obs(i, 1));
            else n_pass++;
        end
    endtask

    task automatic test_const_shadow();
        set_cfg(2, 12, 0, 0, 0);
        pulse(1);
        set_cfg(3, 99, 5, 5, 1);      // mid-frame change must not take effect yet
        capture(LL);
        for (int i = 0; i < LL; i++) begin
            n_total++;
            if (cap[i] !== model_obs(i, 0))
                $display("FAIL const_line0 x=%0d: got %h, expected %h", i, cap[i], model_obs(i, 0));
            else n_pass++;
        end
        repeat (2) @(negedge clk);
        pulse(0);
        capture(200);
        for (int i = 0; i < 200; i++) begin
            n_total++;
            if (cap[i][CH*DW-1:0] !== {CH{12'd12}})
                $display("FAIL const_held x=%0d: got %h, expected %h", i, cap[i][CH*DW-1:0], {CH{12'd12}});
            else n_pass++;
        end
        pulse(1);                     // now CHK_W c=1 is latched
        capture(64);
        n_total++;
        if (cap[0][CH*DW-1:0] !== {CH{12'hfff}} || cap[2][CH*DW-1:0] !== '0)
            $display("FAIL const_to_chk: got x0=%h x2=%h, expected fff.. and 0", cap[0][CH*DW-1:0], cap[2][CH*DW-1:0]);
        else n_pass++;
        for (int i = 0; i < 64; i++) begin
            n_total++;
            if (cap[i] !== model_obs(i, 0))
                $display("FAIL const_to_chk_line x=%0d: got %h, expected %h", i, cap[i], model_obs(i, 0));
            else n_pass++;
        end
    endtask

    task automatic test_checker();
        set_cfg(3, 0, 0, 0, 1);
        pulse(1);
        capture(LL);
        for (int i = 0; i < LL; i++) begin
            n_total++;
            if (cap[i] !== model_obs(i, 0))
                $display("FAIL chkw_line0 x=%0d: got %h, expected %h", i, cap[i], model_obs(i, 0));
            else n_pass++;
        end
        pulse(0);
        capture(32);
        pulse(0);
        capture(32);
        n_total++;
        if ({cap[0][DW-1:0], cap[1][DW-1:0], cap[2][DW-1:0], cap[3][DW-1:0]} !== {12'h000, 12'h000, 12'hfff, 12'hfff}
            || cap[0][CH*DW +: YW] !== YW'(2))
            $display("FAIL chkw_line2_start: got %h %h %h %h line=%0d, expected 000 000 fff fff line=2",
                     cap[0][DW-1:0], cap[1][DW-1:0], cap[2][DW-1:0], cap[3][DW-1:0], cap[0][CH*DW +: YW]);
        else n_pass++;
        set_cfg(4, 0, 0, 0, $urandom_range(0, 7));
        pulse(1);
        for (int y = 0; y < 3; y++) begin
            capture(300);
            for (int i = 0; i < 300; i++) begin
                n_total++;
                if (cap[i] !== model_obs(i, y))
                    $display("FAIL chkb y=%0d x=%0d c=%0d: got %h, expected %h", y, i, m_c, cap[i], model_obs(i, y));
                else n_pass++;
            end
            pulse(0);
        end
    endtask

    task automatic test_ramp();
        set_cfg(5, 0, 2, 2, 0);
        pulse(1);
        capture(16);
        for (int y = 1; y < 4; y++) begin
            pulse(0);
            capture(16);
            for (int i = 0; i < 16; i++) begin
                n_total++;
                if (cap[i] !== model_obs(i, y))
                    $display("FAIL ramp22 y=%0d x=%0d: got %h, expected %h", y, i, cap[i], model_obs(i, y));
                else n_pass++;
            end
        end
        n_total++;
        if (cap[5][CH*DW-1:0] !== {CH{12'd16}})
            $display("FAIL ramp_y3_x5: got %h, expected %h", cap[5][CH*DW-1:0], {CH{12'd16}});
        else n_pass++;
        for (int f = 0; f < 3; f++) begin
            set_cfg(5, 0, $urandom_range(1, 15), $urandom_range(1, 15), 0);
            pulse(1);
            for (int y = 0; y < 2; y++) begin
                capture(LL);
                for (int i = 0; i < LL; i++) begin
                    n_total++;
                    if (cap[i] !== model_obs(i, y))
                        $display("FAIL ramp dx=%0d dy=%0d y=%0d x=%0d: got %h, expected %h",
                                 m_dx, m_dy, y, i, cap[i], model_obs(i, y));
                    else n_pass++;
                end
                repeat ($urandom_range(0, 4)) @(negedge clk);
                if (y == 0) pulse(0);
            end
        end
    endtask

    task automatic test_bars();
        obs_t o;
        set_cfg(6, 0, 0, 0, 0);
        pulse(1);
        capture(LL);
        n_total++;
        if (cap[0][CH*DW-1:0] !== '0 || cap[BAR_W][CH*DW-1:0] !== {12'h000, 12'h000, 12'hfff}
            || cap[7*BAR_W][CH*DW-1:0] !== {CH{12'hfff}})
            $display("FAIL bars_points: got %h / %h / %h, expected 0 / 000000fff / fffffffff",
                     cap[0][CH*DW-1:0], cap[BAR_W][CH*DW-1:0], cap[7*BAR_W][CH*DW-1:0]);
        else n_pass++;
        for (int i = 0; i < LL; i++) begin
            n_total++;
            if (cap[i] !== model_obs(i, 0))
                $display("FAIL bars_line0 x=%0d: got %h, expected %h", i, cap[i], model_obs(i, 0));
            else n_pass++;
        end
        pulse(0);
        capture(500);
        pulse(0);                     // restart mid-line: old line still shows x=500
        o = {bus.pix_valid, bus.line_cnt, bus.pix};
        n_total++;
        if (o !== model_obs(500, 1))
            $display("FAIL bars_restart_gap: got %h, expected %h", o, model_obs(500, 1));
        else n_pass++;
        capture(LL);
        for (int i = 0; i < LL; i++) begin
            n_total++;
            if (cap[i] !== model_obs(i, 2))
                $display("FAIL bars_line2 x=%0d: got %h, expected %h", i, cap[i], model_obs(i, 2));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int n;
        for (int f = 0; f < 4; f++) begin
            set_cfg($urandom_range(0, 7), $urandom_range(0, MAXV), $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 7));
            pulse(1);
            set_cfg($urandom_range(0, 7), $urandom_range(0, MAXV), $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 7));
            for (int y = 0; y < 3; y++) begin
                n = ($urandom_range(0, 1) == 1) ? LL : $urandom_range(16, LL - 1);
                capture(n);
                for (int i = 0; i < n; i++) begin
                    n_total++;
                    if (cap[i] !== model_obs(i, y))
                        $display("FAIL random f=%0d mode=%0d y=%0d x=%0d: got %h, expected %h",
                                 f, m_mode, y, i, cap[i], model_obs(i, y));
                    else n_pass++;
                end
                if (n == LL) repeat ($urandom_range(0, 5)) @(negedge clk);
                pulse(0);
            end
        end
    endtask

    initial begin
        bus.sync = 1'b0;
        bus.f_sync = 1'b0;
        test_reset();
        test_count();
        test_const_shadow();
        test_checker();
        test_ramp();
        test_bars();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
